// File: rtl/l15_refill_pkg.sv
// Shared types for the L1.5 refill path: collector FSM states and beat-counter sizing.
package l15_refill_pkg;

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    DROP,
    DROP_THEN_OUT,
    OUTPUT
  } refill_coll_state_e;

  // A single-beat line would still need a 1-bit counter to stay legal.
  function automatic int unsigned BEAT_CNT_W(input int unsigned line_beats);
    return (line_beats > 1) ? $clog2(line_beats) : 1;
  endfunction

endpackage

// File: rtl/refill_resp_collector.sv
// Assembles multi-beat L2 refill responses into L1.5 lines, checks the first-beat ID
// against the refill tracker, and pops the tracker entry when the line is written.
module refill_resp_collector
  import l15_refill_pkg::*;
#(
  parameter int unsigned ID_WIDTH   = 14,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned LINE_BEATS = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             resp_valid_i,
  output logic                             resp_ready_o,
  input  logic [ID_WIDTH-1:0]              resp_id_i,
  input  logic [DATA_WIDTH-1:0]            resp_data_i,
  input  logic                             resp_last_i,
  input  logic                             resp_err_i,
  output logic                             check_req_o,
  output logic [ID_WIDTH-1:0]              check_id_o,
  input  logic                             check_is_valid_i,
  output logic                             pop_o,
  output logic [ID_WIDTH-1:0]              pop_id_o,
  input  logic                             pop_error_i,
  output logic                             line_valid_o,
  input  logic                             line_ready_i,
  output logic [ID_WIDTH-1:0]              line_id_o,
  output logic [LINE_BEATS*DATA_WIDTH-1:0] line_data_o,
  output logic                             line_err_o,
  output logic                             unknown_id_o,
  output logic                             pop_fail_o
);

  localparam int unsigned     CNT_W     = BEAT_CNT_W(LINE_BEATS);
  localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(LINE_BEATS - 1);

  refill_coll_state_e state_q, state_d;

  logic [CNT_W-1:0]                           cnt_q;
  logic [LINE_BEATS-1:0][DATA_WIDTH-1:0]      line_q;
  logic [ID_WIDTH-1:0]                        id_q;
  logic                                       err_q;
  logic                                       unknown_q;
  logic                                       pop_fail_q;
  logic                                       beat_acc;
  logic                                       cnt_at_last;

  // Ready depends only on state, so no path from line_ready_i or the tracker reaches it.
  assign resp_ready_o = (state_q != OUTPUT);
  assign beat_acc     = resp_valid_i & resp_ready_o;
  assign cnt_at_last  = (cnt_q == LAST_SLOT);

  assign check_id_o   = resp_id_i;
  assign line_valid_o = (state_q == OUTPUT);
  assign line_id_o    = id_q;
  assign line_data_o  = line_q;
  assign line_err_o   = err_q;
  assign pop_o        = line_valid_o & line_ready_i;
  assign pop_id_o     = id_q;
  assign unknown_id_o = unknown_q;
  assign pop_fail_o   = pop_fail_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    check_req_o = 1'b0;
    case (state_q)
      IDLE: begin
        check_req_o = resp_valid_i;
        if (beat_acc) begin
          if (check_is_valid_i) begin
            state_d = resp_last_i ? OUTPUT : COLLECT;
          end else begin
            state_d = resp_last_i ? IDLE : DROP;
          end
        end
      end
      COLLECT: begin
        if (beat_acc) begin
          if (cnt_at_last) begin
            state_d = resp_last_i ? OUTPUT : DROP_THEN_OUT;
          end else if (resp_last_i) begin
            state_d = OUTPUT;
          end
        end
      end
      DROP: begin
        if (beat_acc && resp_last_i) begin
          state_d = IDLE;
        end
      end
      DROP_THEN_OUT: begin
        if (beat_acc && resp_last_i) begin
          state_d = OUTPUT;
        end
      end
      OUTPUT: begin
        if (line_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Line buffer, ID and error accumulation. The buffer is cleared on handoff so short
  // bursts leave zeros in the slots they never reached.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      line_q <= '0;
      id_q   <= '0;
      err_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (beat_acc && check_is_valid_i) begin
            line_q[0] <= resp_data_i;
            id_q      <= resp_id_i;
            err_q     <= resp_err_i | resp_last_i;
            cnt_q     <= resp_last_i ? '0 : CNT_W'(1);
          end
        end
        COLLECT: begin
          if (beat_acc) begin
            line_q[cnt_q] <= resp_data_i;
            err_q <= err_q | resp_err_i
                   | (resp_last_i & ~cnt_at_last)
                   | (~resp_last_i & cnt_at_last);
            cnt_q <= resp_last_i ? '0 : cnt_q + CNT_W'(1);
            if (resp_last_i) begin
              for (int k = 0; k < int'(LINE_BEATS); k++) begin
                if (k > int'(cnt_q)) begin
                  line_q[k] <= '0;
                end
              end
            end
          end
        end
        OUTPUT: begin
          if (line_ready_i) begin
            line_q <= '0;
            id_q   <= '0;
            err_q  <= 1'b0;
            cnt_q  <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      unknown_q  <= 1'b0;
      pop_fail_q <= 1'b0;
    end else begin
      unknown_q  <= (state_q == IDLE) & beat_acc & ~check_is_valid_i;
      pop_fail_q <= pop_o & pop_error_i;
    end
  end

endmodule

// File: doc/refill_resp_collector.md
# refill_resp_collector

Collects multi-beat refill responses from L2 into full L1.5 cache lines, just upstream of the refill tracker's pop side. Validates each incoming response ID against the tracker's outstanding table, assembles the beats of a line, hands the line to the L1.5 data-array write port, and pops the tracker entry when the line is accepted. Unknown IDs and malformed bursts are discarded or flagged, never written silently.

## Interface
- `ID_WIDTH`, 14: refill transaction ID width; matches the tracker.
- `DATA_WIDTH`, 64: bits per response beat.
- `LINE_BEATS`, 4: beats per cache line; power of two, ≥2.
- `clk` in 1: clock; single clock domain.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `resp_valid_i` in 1: response beat valid.
- `resp_ready_o` out 1: response beat accepted when high together with `resp_valid_i`.
- `resp_id_i` in ID_WIDTH: beat ID.
- `resp_data_i` in DATA_WIDTH: beat data.
- `resp_last_i` in 1: final beat of the burst.
- `resp_err_i` in 1: slave error on this beat.
- `check_req_o` out 1: tracker lookup request; combinational.
- `check_id_o` out ID_WIDTH: lookup ID, equal to `resp_id_i`.
- `check_is_valid_i` in 1: tracker hit; combinational, same cycle.
- `pop_o` out 1: tracker pop strobe.
- `pop_id_o` out ID_WIDTH: ID to pop.
- `pop_error_i` in 1: tracker pop miss; meaningful only while `pop_o`=1.
- `line_valid_o` out 1: assembled line available.
- `line_ready_i` in 1: line accepted by the cache write port.
- `line_id_o` out ID_WIDTH: ID of the line.
- `line_data_o` out LINE_BEATS*DATA_WIDTH: beat k at bits [k*DATA_WIDTH +: DATA_WIDTH].
- `line_err_o` out 1: line is corrupt (slave error or length error).
- `unknown_id_o` out 1: one-cycle pulse when a first beat misses in the tracker.
- `pop_fail_o` out 1: one-cycle pulse when a pop handshake sees `pop_error_i`.

## Operation
- L2 returns the beats of one line contiguously, with no interleaving between IDs. The ID on non-first beats is not checked.
- **IDLE**
  - `resp_ready_o`=1, `check_req_o`=`resp_valid_i`.
  - On an accepted beat with `check_is_valid_i`=1: store beat 0, latch ID, set err=`resp_err_i`, set beat count to 1.
    - If `resp_last_i`=1, set err and go to OUTPUT. This is a length error; beats 1..N-1 are zero.
    - Otherwise go to COLLECT.
  - On an accepted beat with `check_is_valid_i`=0: pulse `unknown_id_o` and drop the beat.
    - Stay in IDLE if `resp_last_i`=1, else go to DROP.
- **COLLECT**
  - `resp_ready_o`=1, `check_req_o`=0. Each accepted beat is written to slot `cnt`, err |= `resp_err_i`, `cnt`++.
  - Early `resp_last_i` (cnt<LINE_BEATS-1): set err, zero the remaining slots, go to OUTPUT.
  - Beat at cnt=LINE_BEATS-1:
    - With `resp_last_i`=1: go to OUTPUT.
    - With `resp_last_i`=0: set err, go to DROP_THEN_OUT.
- **DROP**: `resp_ready_o`=1. Discard beats until an accepted `resp_last_i`, then go to IDLE.
- **DROP_THEN_OUT**: same as DROP, but on the last beat go to OUTPUT.
- **OUTPUT**
  - `resp_ready_o`=0, `line_valid_o`=1. Data, ID and err are stable until the handshake.
  - `pop_o` = `line_valid_o & line_ready_i`, `pop_id_o` = `line_id_o`.
  - On handshake, go to IDLE and clear the line buffer and err.
  - If `pop_error_i`=1 during the handshake, pulse `pop_fail_o` in the next cycle.
- The tracker entry stays live until the line is written, so a duplicate-miss check still hits during assembly.

## Timing
- Reset values: state IDLE.
  - All outputs 0, except `resp_ready_o`=1 and `check_id_o`=`resp_id_i`.
  - `line_data_o` is 0.
- Latency: `line_valid_o` rises the cycle after the last accepted beat.
- Throughput: a line of N beats takes N cycles plus at least 1 OUTPUT cycle. There is a one-cycle response bubble per line.
- `check_req_o`, `check_id_o`, `pop_o` and `pop_id_o` are combinational. The tracker answers in the same cycle; there is no registered path.
- `unknown_id_o` is registered and high for exactly one cycle after the offending beat. `pop_fail_o` is also registered.
- `line_valid_o` stays high until `line_ready_i`, with no combinational dependency of `line_valid_o` on `line_ready_i`.
- Beat counter width is $clog2(LINE_BEATS) and wraps to 0 on leaving COLLECT.
- Reset mid-line discards the partial line and issues no pop.

## Structure
- Shared package `l15_refill_pkg`:
  - `refill_coll_state_e` enum: IDLE, COLLECT, DROP, DROP_THEN_OUT, OUTPUT.
  - `BEAT_CNT_W` function of LINE_BEATS.
- Single module; the line buffer is an inline register array. No sub-module.

## Test plan
- Push ID 0x15 into the tracker; 4 beats 0xA0..0xA3 with last on beat 3 → line data {A3,A2,A1,A0}, err 0, pop_o with ID 0x15 on handshake, pop_fail_o 0.
- First beat ID 0x7 absent from the tracker, 4-beat burst → unknown_id_o one pulse, all 4 beats consumed, no line_valid_o, no pop.
- Tracked ID, `resp_last_i` on beat 1 → line_err_o=1, slots 2–3 zero, line still handed off and popped.
- Tracked ID, 6 beats with last on beat 5 → line holds beats 0–3, err=1, beats 4–5 dropped, then OUTPUT.
- `line_ready_i` held low 10 cycles with back-to-back responses pending → resp_ready_o=0 throughout, line stable; next line assembles correctly after release.
- Assert rst_n low after beat 2 → outputs at reset values next edge, no pop; a fresh 4-beat line after reset completes normally.
